// File: rtl/ddfs_sweep_controller.sv
// Linear frequency-sweep (chirp) sequencer for the DDFS control word.
// Steps from start to stop word, holding each word i_dwell+1 cycles; single-shot or continuous.
module ddfs_sweep_controller #(
    parameter int FREQ_WIDTH  = 32,
    parameter int DWELL_WIDTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic                   i_abort,
    input  logic [FREQ_WIDTH-1:0]  i_start_freq,
    input  logic [FREQ_WIDTH-1:0]  i_stop_freq,
    input  logic [FREQ_WIDTH-1:0]  i_step,
    input  logic [DWELL_WIDTH-1:0] i_dwell,
    input  logic                   i_continuous,
    output logic [FREQ_WIDTH-1:0]  o_freq_control,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_step_strobe,
    output logic                   o_dbg_state
);

    // Handshake: a request is taken when i_start=1, i_abort=0 and o_busy=0 at a rising edge;
    // o_busy is the "not ready" indication and stays high until completion or abort.
    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [FREQ_WIDTH-1:0]  freq_q, freq_d;
    logic [FREQ_WIDTH-1:0]  start_q, start_d;
    logic [FREQ_WIDTH-1:0]  stop_q, stop_d;
    logic [FREQ_WIDTH-1:0]  step_q, step_d;
    logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
    logic [DWELL_WIDTH-1:0] cnt_q, cnt_d;
    logic                   cont_q, cont_d;
    logic                   up_q, up_d;
    logic                   done_q, done_d;
    logic                   strobe_q, strobe_d;

    logic [FREQ_WIDTH:0]    up_sum;
    logic [FREQ_WIDTH-1:0]  dn_diff;
    logic [FREQ_WIDTH-1:0]  next_word;

    // Extra carry bit on the up path so an overflowing add is seen as "past stop".
    always_comb begin
        up_sum  = {1'b0, freq_q} + {1'b0, step_q};
        dn_diff = freq_q - step_q;
        if (up_q) begin
            if (up_sum > {1'b0, stop_q}) begin
                next_word = stop_q;
            end else begin
                next_word = up_sum[FREQ_WIDTH-1:0];
            end
        end else begin
            if ((freq_q < step_q) || (dn_diff < stop_q)) begin
                next_word = stop_q;
            end else begin
                next_word = dn_diff;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        freq_d   = freq_q;
        start_d  = start_q;
        stop_d   = stop_q;
        step_d   = step_q;
        dwell_d  = dwell_q;
        cnt_d    = cnt_q;
        cont_d   = cont_q;
        up_d     = up_q;
        done_d   = 1'b0;
        strobe_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_start && !i_abort) begin
                    start_d  = i_start_freq;
                    stop_d   = i_stop_freq;
                    step_d   = (i_step == '0) ? {{(FREQ_WIDTH-1){1'b0}}, 1'b1} : i_step;
                    dwell_d  = i_dwell;
                    cont_d   = i_continuous;
                    up_d     = (i_stop_freq >= i_start_freq);
                    freq_d   = i_start_freq;
                    cnt_d    = i_dwell;
                    strobe_d = 1'b1;
                    state_d  = SWEEP;
                end
            end
            SWEEP: begin
                if (i_abort) begin
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (freq_q != stop_q) begin
                    freq_d   = next_word;
                    cnt_d    = dwell_q;
                    strobe_d = 1'b1;
                end else if (cont_q) begin
                    freq_d   = start_q;
                    cnt_d    = dwell_q;
                    strobe_d = 1'b1;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            freq_q   <= '0;
            start_q  <= '0;
            stop_q   <= '0;
            step_q   <= '0;
            dwell_q  <= '0;
            cnt_q    <= '0;
            cont_q   <= 1'b0;
            up_q     <= 1'b0;
            done_q   <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            freq_q   <= freq_d;
            start_q  <= start_d;
            stop_q   <= stop_d;
            step_q   <= step_d;
            dwell_q  <= dwell_d;
            cnt_q    <= cnt_d;
            cont_q   <= cont_d;
            up_q     <= up_d;
            done_q   <= done_d;
            strobe_q <= strobe_d;
        end
    end

    assign o_freq_control = freq_q;
    assign o_busy         = (state_q == SWEEP);
    assign o_done         = done_q;
    assign o_step_strobe  = strobe_q;
    assign o_dbg_state    = state_q;

endmodule

// File: tb/tb_ddfs_sweep_controller.sv
// Directed bench for ddfs_sweep_controller: hand-computed word sequences, status pulses and reset.
`timescale 1ns/1ps
module tb_ddfs_sweep_controller;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [31:0] start_freq;
    logic [31:0] stop_freq;
    logic [31:0] step;
    logic [15:0] dwell;
    logic        continuous;
    logic [31:0] freq_control;
    logic        busy;
    logic        done;
    logic        step_strobe;
    logic        dbg_state;

    logic [31:0] exp_q[$];
    int          n_cmp;
    int          n_err;

    ddfs_sweep_controller dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_start        (start),
        .i_abort        (abort),
        .i_start_freq   (start_freq),
        .i_stop_freq    (stop_freq),
        .i_step         (step),
        .i_dwell        (dwell),
        .i_continuous   (continuous),
        .o_freq_control (freq_control),
        .o_busy         (busy),
        .o_done         (done),
        .o_step_strobe  (step_strobe),
        .o_dbg_state    (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed=0x%08h required=0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives a request for one edge; returns 1 ns after the accepting edge.
    task automatic do_start(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                            input logic [15:0] d, input logic c);
        start_freq = s;
        stop_freq  = e;
        step       = st;
        dwell      = d;
        continuous = c;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    // Consumes exp_q: each word must be visible d+1 cycles, strobe on its first cycle only.
    task automatic check_seq(input string tag, input int d);
        logic [31:0] w;
        while (exp_q.size() > 0) begin
            w = exp_q.pop_front();
            for (int c = 0; c <= d; c++) begin
                check({tag, "_word"}, freq_control, w);
                check({tag, "_strobe"}, {31'd0, step_strobe}, {31'd0, (c == 0)});
                check({tag, "_busy"}, {31'd0, busy}, 32'd1);
                check({tag, "_done_low"}, {31'd0, done}, 32'd0);
                tick();
            end
        end
    endtask

    task automatic check_done(input string tag, input logic [31:0] stop_w, input logic chk_clear);
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
        check({tag, "_hold"}, freq_control, stop_w);
        check({tag, "_no_strobe"}, {31'd0, step_strobe}, 32'd0);
        if (chk_clear) begin
            tick();
            check({tag, "_done_clr"}, {31'd0, done}, 32'd0);
            check({tag, "_hold2"}, freq_control, stop_w);
            check({tag, "_idle"}, {31'd0, dbg_state}, 32'd0);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        start_freq = '0;
        stop_freq  = '0;
        step       = '0;
        dwell      = '0;
        continuous = 1'b0;

        #3;
        check("rst_freq", freq_control, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_strobe", {31'd0, step_strobe}, 32'd0);
        #9 rst_n = 1'b1;
        tick();

        // up sweep, dwell 3, five words
        do_start(32'h000F_FFFF, 32'h004F_FFFF, 32'h0010_0000, 16'd3, 1'b0);
        exp_q = '{32'h000F_FFFF, 32'h001F_FFFF, 32'h002F_FFFF, 32'h003F_FFFF, 32'h004F_FFFF};
        check_seq("up", 3);
        check_done("up", 32'h004F_FFFF, 1'b0);

        // new start accepted in the done cycle; clamp on last up step
        do_start(32'd0, 32'd10, 32'd4, 16'd0, 1'b0);
        exp_q = '{32'd0, 32'd4, 32'd8, 32'd10};
        check_seq("clamp_up", 0);
        check_done("clamp_up", 32'd10, 1'b1);

        do_start(32'd10, 32'd0, 32'd4, 16'd0, 1'b0);
        exp_q = '{32'd10, 32'd6, 32'd2, 32'd0};
        check_seq("down", 0);
        check_done("down", 32'd0, 1'b1);

        // carry-out must clamp to stop, not wrap
        do_start(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h0000_0020, 16'd1, 1'b0);
        exp_q = '{32'hFFFF_FFF0, 32'hFFFF_FFFF};
        check_seq("ovf", 1);
        check_done("ovf", 32'hFFFF_FFFF, 1'b1);

        // continuous wrap, start ignored while busy, then abort at word 1
        do_start(32'd0, 32'd2, 32'd1, 16'd0, 1'b1);
        exp_q = '{32'd0, 32'd1};
        check_seq("cont_a", 0);
        start = 1'b1;
        start_freq = 32'd7;
        exp_q = '{32'd2, 32'd0};
        check_seq("cont_b", 0);
        start = 1'b0;
        check("cont_w1", freq_control, 32'd1);
        check("cont_w1_strobe", {31'd0, step_strobe}, 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_hold", freq_control, 32'd1);
        check("abort_no_done", {31'd0, done}, 32'd0);
        check("abort_no_strobe", {31'd0, step_strobe}, 32'd0);
        tick();
        check("abort_stays_idle", {31'd0, busy}, 32'd0);
        check("abort_hold2", freq_control, 32'd1);

        // start == stop, dwell 5
        do_start(32'h0000_1234, 32'h0000_1234, 32'd8, 16'd5, 1'b0);
        exp_q = '{32'h0000_1234};
        check_seq("single", 5);
        check_done("single", 32'h0000_1234, 1'b1);

        // step 0 behaves as step 1
        do_start(32'd0, 32'd2, 32'd0, 16'd0, 1'b0);
        exp_q = '{32'd0, 32'd1, 32'd2};
        check_seq("step0", 0);
        check_done("step0", 32'd2, 1'b1);

        // start with abort in IDLE is ignored
        start_freq = 32'd99;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("sa_busy", {31'd0, busy}, 32'd0);
        check("sa_strobe", {31'd0, step_strobe}, 32'd0);
        check("sa_hold", freq_control, 32'd2);

        // async reset mid-sweep
        do_start(32'd100, 32'd200, 32'd10, 16'd2, 1'b0);
        exp_q = '{32'd100, 32'd110};
        check_seq("pre_rst", 2);
        #2 rst_n = 1'b0;
        #1;
        check("arst_freq", freq_control, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_strobe", {31'd0, step_strobe}, 32'd0);
        #3 rst_n = 1'b1;
        tick();
        tick();
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        check("post_rst_freq", freq_control, 32'd0);
        check("post_rst_strobe", {31'd0, step_strobe}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
